led_matrix_scan: RTL and testbench
==================================

# led_matrix_scan

Double-buffered 8x8 LED matrix refresh engine that sits directly downstream of the CPU's VPOKE video-register writes. It accepts row writes into a back buffer and swaps buffers only on a frame boundary, so a partly drawn picture is never shown. It drives the row/column pins with inter-row blanking against ghosting and 4-level brightness PWM. It replaces the ad-hoc counter-slice scanning in the top level.

## Interface
- DWELL, 1024: drive cycles per row; must be a multiple of 4 and at least 4.
- BLANK, 16: blanking cycles before each row; at least 1.
- clock  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- wr_en  in  1  write strobe into back buffer
- wr_addr  in  3  row index of write
- wr_data  in  8  column bits of write (bit n = column n lit)
- rd_addr  in  3  back-buffer read row (for CPU read-modify-write)
- rd_data  out  8  combinational back-buffer contents at rd_addr
- swap_req  in  1  one-cycle request to present back buffer
- swap_ack  out  1  one-cycle pulse when swap takes effect
- swap_pending  out  1  request latched, not yet performed
- bright  in  2  brightness level 0..3, sampled at the start of each row's drive phase
- frame_start  out  1  one-cycle pulse on the first cycle of each frame
- row  out  8  row drive, active-low one-hot or all-ones
- col  out  8  column drive, active-high

## Operation
- Storage: two banks of 8 x 8 bits. Register front_sel selects the displayed bank; the other bank is the back bank.
- Write: on a clock edge with wr_en=1, back[wr_addr] <= wr_data. The front bank is never writable. rd_data = back[rd_addr], combinational, including the same-cycle new value only after the edge.
- State machine, states BLANK and DRIVE, with row index r (0..7) and a cycle counter:
  - BLANK: lasts BLANK cycles; row=8'hFF, col=0.
  - DRIVE: lasts DWELL cycles; row=~(1<<r).
  - On drive cycle k (0-based), col=front[r] if k < on_len, else col=0.
  - on_len=(bright_s+1)*(DWELL/4), where bright_s is bright sampled on the BLANK->DRIVE transition.
  - DRIVE end: r <= r+1, wrapping 7->0; the next state is BLANK.
- Frame: 8*(BLANK+DWELL) cycles, starting at BLANK of row 0.
- Swap handshake:
  - swap_req=1 sets swap_pending.
  - A further swap_req while pending has no extra effect; there is no queueing.
  - At the edge ending the last DRIVE cycle of row 7, if swap_pending (or swap_req in that same cycle): front_sel toggles, swap_pending clears, and swap_ack=1 for the first cycle of the new frame (coincident with frame_start).
- A write in the same cycle as the swap edge targets the pre-swap back bank; that data becomes visible in the new frame.
- Brightness changes mid-row take effect at the next row.
- Reset (any time, including mid-row or mid-swap):
  - state=BLANK, r=0, counter=0, front_sel=0, swap_pending=0.
  - Both banks cleared to 0.
  - row=8'hFF, col=0, swap_ack=0.
  - frame_start=1 on the first cycle after rst deasserts; 0 while rst is low.

## Timing
- All outputs except rd_data are registered. Values describe the cycle in which the output is visible.
- The first post-reset cycle is BLANK cycle 0 of row 0 of frame 0.
- Write-to-display latency: a written value appears only after a swap. That is at most one full frame plus one cycle after swap_req, and at least one cycle when swap_req lands on the last frame cycle.
- swap_ack and frame_start are exactly 1 cycle wide.
- swap_pending rises the cycle after swap_req and falls in the swap_ack cycle.
- No cycle ever has row asserted during BLANK, nor two rows asserted at once.

## Test plan
Parameters DWELL=8, BLANK=2 throughout (frame = 80 cycles).
- Reset / idle: release rst with no writes -> row=FF for 2 cycles, then FE for 8 cycles; col=00 throughout; frame_start at cycles 0, 80, 160; swap_ack never set.
- Write and swap: write row 3=8'hA5, pulse swap_req at cycle 10 -> swap_pending high cycles 11..79; swap_ack and frame_start at cycle 80; col=A5 while row=F7 (cycles 112..113 with bright=0) in frame 1 and later. Before the swap, col never shows A5.
- Brightness: bright=3 with row 0=FF swapped in -> col=FF for all 8 drive cycles. bright=1 -> col=FF for 4 drive cycles, then 00. Change bright in the middle of row 0 -> row 0 keeps its old duty.
- Boundary swap: swap_req exactly on cycle 79 -> swap at cycle 80 with swap_ack. A second swap_req during pending -> still one swap_ack; the banks toggle once.
- Same-edge write: write row 0=8'h3C on cycle 79 with a swap pending -> frame 1 row 0 shows 3C. rd_data for rd_addr=0 after the swap returns the old front contents.
- Reset mid-operation: assert rst during the DRIVE of row 5 with a swap pending -> outputs go immediately to row=FF, col=00, swap_pending=0; after release the frame restarts at row 0 and all banks read 00.

Source files
------------

// File: rtl/led_matrix_scan_if.sv
// Signal bundle between the CPU's VPOKE write path and the LED matrix refresh engine.
// Swap handshake: swap_req is a one-cycle request. The engine latches it as swap_pending
// and performs it at the next frame boundary, answering with a one-cycle swap_ack.
// Requests arriving while one is pending merge into it; there is no queueing.
interface led_matrix_scan_if;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic       swap_req;
    logic       swap_ack;
    logic       swap_pending;
    logic [1:0] bright;
    logic       frame_start;
    logic [7:0] row;
    logic [7:0] col;
    logic       dbg_drive;
    logic [2:0] dbg_row;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, swap_req, bright,
        input  rd_data, swap_ack, swap_pending, frame_start, row, col, dbg_drive, dbg_row
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, swap_req, bright,
        output rd_data, swap_ack, swap_pending, frame_start, row, col, dbg_drive, dbg_row
    );
endinterface

// File: rtl/led_matrix_scan.sv
// Double-buffered 8x8 LED matrix scanner: back-bank writes, frame-boundary swap,
// inter-row blanking and 4-level PWM brightness. All pin outputs are registered.
module led_matrix_scan #(
    parameter int DWELL = 1024,
    parameter int BLANK = 16
) (
    input  logic             clock,
    input  logic             rst,
    led_matrix_scan_if.slave bus
);
    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int ON_W    = CNT_W + 1;
    localparam int STEP    = DWELL / 4;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            r_q, r_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            bright_s_q, bright_s_d;
    logic                  front_sel_q, front_sel_d;
    logic                  pending_q, pending_d;
    logic                  run_q;
    logic                  swap_now;
    logic [1:0][7:0][7:0]  bank_q, bank_d;
    logic [ON_W-1:0]       on_len;

    logic [7:0]            row_q, row_d;
    logic [7:0]            col_q, col_d;
    logic                  frame_start_q, frame_start_d;
    logic                  swap_ack_q, swap_ack_d;

    // run_q holds the position at BLANK 0 of row 0 for the first edge after reset, so the
    // output registers load that cycle's values and frame_start shows in the first live cycle.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        bright_s_d  = bright_s_q;
        front_sel_d = front_sel_q;
        pending_d   = pending_q | bus.swap_req;
        swap_now    = 1'b0;
        bank_d      = bank_q;

        if (bus.wr_en) begin
            bank_d[~front_sel_q][bus.wr_addr] = bus.wr_data;
        end

        if (run_q) begin
            unique case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d    = ST_DRIVE;
                        cnt_d      = '0;
                        bright_s_d = bus.bright;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        r_d     = r_q + 3'd1;
                        if ((r_q == 3'd7) && pending_d) begin
                            swap_now    = 1'b1;
                            front_sel_d = ~front_sel_q;
                            pending_d   = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign on_len = ON_W'((32'(bright_s_d) + 32'd1) * STEP);

    // Decode the pins for the cycle being entered. A swap edge always enters BLANK,
    // so reading the pre-edge bank contents here never misses a same-edge write.
    always_comb begin
        row_d         = 8'hFF;
        col_d         = 8'h00;
        frame_start_d = (state_d == ST_BLANK) && (r_d == 3'd0) && (cnt_d == '0);
        swap_ack_d    = swap_now;
        if (state_d == ST_DRIVE) begin
            row_d = ~(8'h01 << r_d);
            if ({1'b0, cnt_d} < on_len) begin
                col_d = bank_q[front_sel_d][r_d];
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_BLANK;
            r_q           <= '0;
            cnt_q         <= '0;
            bright_s_q    <= '0;
            front_sel_q   <= 1'b0;
            pending_q     <= 1'b0;
            run_q         <= 1'b0;
            bank_q        <= '0;
            row_q         <= 8'hFF;
            col_q         <= 8'h00;
            frame_start_q <= 1'b0;
            swap_ack_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            r_q           <= r_d;
            cnt_q         <= cnt_d;
            bright_s_q    <= bright_s_d;
            front_sel_q   <= front_sel_d;
            pending_q     <= pending_d;
            run_q         <= 1'b1;
            bank_q        <= bank_d;
            row_q         <= row_d;
            col_q         <= col_d;
            frame_start_q <= frame_start_d;
            swap_ack_q    <= swap_ack_d;
        end
    end

    assign bus.rd_data      = bank_q[~front_sel_q][bus.rd_addr];
    assign bus.row          = row_q;
    assign bus.col          = col_q;
    assign bus.frame_start  = frame_start_q;
    assign bus.swap_ack     = swap_ack_q;
    assign bus.swap_pending = pending_q;
    assign bus.dbg_drive    = (state_q == ST_DRIVE);
    assign bus.dbg_row      = r_q;
endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan with DWELL=8, BLANK=2 (80-cycle frame).
// Cycle 0 is the first cycle after reset release; each scenario starts from reset.
module tb_led_matrix_scan;
    localparam int DWELL   = 8;
    localparam int BLANK   = 2;
    localparam int ROW_CYC = DWELL + BLANK;
    localparam int FRAME   = 8 * ROW_CYC;

    logic clock = 1'b0;
    logic rst   = 1'b1;

    led_matrix_scan_if bus();

    led_matrix_scan #(
        .DWELL(DWELL),
        .BLANK(BLANK)
    ) dut (
        .clock(clock),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        logic       wr_en;
        logic [2:0] wr_addr;
        logic [7:0] wr_data;
        logic       swap_req;
        logic       set_br;
        logic [1:0] br;
        logic       chk_rd;
        logic [2:0] rd_addr;
        logic [7:0] e_rd;
        logic       chk_out;
        logic [7:0] e_row;
        logic [7:0] e_col;
        logic       e_fs;
        logic       e_ack;
        logic       e_pend;
    } vec_t;

    vec_t       vt[$];
    logic [7:0] exp_q[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] forbid_col = 8'h00;
    int         forbid_until = 0;

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%02h want=%02h", name, cyc, act, want);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t new_rec(input int c);
        vec_t v;
        v.cyc = c;      v.wr_en = 1'b0;   v.wr_addr = '0;  v.wr_data = '0;
        v.swap_req = 1'b0; v.set_br = 1'b0; v.br = '0;
        v.chk_rd = 1'b0; v.rd_addr = '0;   v.e_rd = '0;
        v.chk_out = 1'b0; v.e_row = '0;    v.e_col = '0;
        v.e_fs = 1'b0;  v.e_ack = 1'b0;   v.e_pend = 1'b0;
        return v;
    endfunction

    function automatic void add_wr(input int c, input logic [2:0] a, input logic [7:0] d);
        vec_t v = new_rec(c);
        v.wr_en = 1'b1; v.wr_addr = a; v.wr_data = d;
        vt.push_back(v);
    endfunction

    function automatic void add_swap(input int c);
        vec_t v = new_rec(c);
        v.swap_req = 1'b1;
        vt.push_back(v);
    endfunction

    function automatic void add_br(input int c, input logic [1:0] b);
        vec_t v = new_rec(c);
        v.set_br = 1'b1; v.br = b;
        vt.push_back(v);
    endfunction

    function automatic void add_rd(input int c, input logic [2:0] a, input logic [7:0] e);
        vec_t v = new_rec(c);
        v.chk_rd = 1'b1; v.rd_addr = a; v.e_rd = e;
        vt.push_back(v);
    endfunction

    function automatic void add_out(input int c, input logic [7:0] r, input logic [7:0] cl,
                                    input logic fs, input logic ack, input logic pend);
        vec_t v = new_rec(c);
        v.chk_out = 1'b1; v.e_row = r; v.e_col = cl;
        v.e_fs = fs; v.e_ack = ack; v.e_pend = pend;
        vt.push_back(v);
    endfunction

    task automatic check_reset_outputs();
        chk8("rst_row", bus.row, 8'hFF);
        chk8("rst_col", bus.col, 8'h00);
        chk1("rst_frame_start", bus.frame_start, 1'b0);
        chk1("rst_swap_ack", bus.swap_ack, 1'b0);
        chk1("rst_swap_pending", bus.swap_pending, 1'b0);
    endtask

    task automatic release_reset();
        @(negedge clock);
        rst = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_addr  = '0;
        bus.swap_req = 1'b0;
        bus.bright   = 2'd0;
        rst = 1'b0;
        tick();
        tick();
        check_reset_outputs();
        release_reset();
    endtask

    // Scan shape that holds in every frame regardless of picture contents.
    task automatic check_frame_shape(input int c);
        int         p;
        int         r;
        int         k;
        logic [7:0] one;
        logic [7:0] want_row;
        p   = c % FRAME;
        r   = p / ROW_CYC;
        k   = p % ROW_CYC;
        one = 8'h01;
        want_row = (k < BLANK) ? 8'hFF : ~(one << r);
        chk8("row_scan", bus.row, want_row);
        chk1("frame_start_pulse", bus.frame_start, p == 0);
        if (p != 0) chk1("swap_ack_idle", bus.swap_ack, 1'b0);
        if (k < BLANK) chk8("col_blank", bus.col, 8'h00);
        if (c < forbid_until) begin
            n_cmp++;
            if (bus.col === forbid_col) begin
                n_fail++;
                $display("FAIL early_col cyc=%0d got=%02h want=not %02h", cyc, bus.col, forbid_col);
            end
        end
    endtask

    task automatic apply_rec(input vec_t v);
        if (v.wr_en) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = v.wr_addr;
            bus.wr_data = v.wr_data;
        end
        if (v.swap_req) bus.swap_req = 1'b1;
        if (v.set_br) bus.bright = v.br;
        if (v.chk_out) begin
            chk8("row", bus.row, v.e_row);
            chk8("col", bus.col, v.e_col);
            chk1("frame_start", bus.frame_start, v.e_fs);
            chk1("swap_ack", bus.swap_ack, v.e_ack);
            chk1("swap_pending", bus.swap_pending, v.e_pend);
        end
        if (v.chk_rd) begin
            bus.rd_addr = v.rd_addr;
            #1;
            chk8("rd_data", bus.rd_data, v.e_rd);
        end
    endtask

    task automatic run_vectors();
        int last = 0;
        foreach (vt[i]) if (vt[i].cyc > last) last = vt[i].cyc;
        for (int c = 0; c <= last; c++) begin
            cyc = c;
            bus.wr_en    = 1'b0;
            bus.swap_req = 1'b0;
            check_frame_shape(c);
            foreach (vt[i]) begin
                if (vt[i].cyc == c) apply_rec(vt[i]);
            end
            tick();
        end
        bus.wr_en    = 1'b0;
        bus.swap_req = 1'b0;
        vt.delete();
    endtask

    initial begin
        // Idle scan, then write row 3 and swap it in.
        do_reset();
        forbid_col = 8'hA5;
        forbid_until = FRAME;
        add_wr(0, 3'd3, 8'hA5);
        add_out(0,   8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
        add_out(1,   8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        add_out(2,   8'hFE, 8'h00, 1'b0, 1'b0, 1'b0);
        add_out(9,   8'hFE, 8'h00, 1'b0, 1'b0, 1'b0);
        add_swap(10);
        add_out(10,  8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        add_out(11,  8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
        add_out(12,  8'hFD, 8'h00, 1'b0, 1'b0, 1'b1);
        add_out(32,  8'hF7, 8'h00, 1'b0, 1'b0, 1'b1);
        add_out(79,  8'h7F, 8'h00, 1'b0, 1'b0, 1'b1);
        add_out(80,  8'hFF, 8'h00, 1'b1, 1'b1, 1'b0);
        add_out(81,  8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        add_out(112, 8'hF7, 8'hA5, 1'b0, 1'b0, 1'b0);
        add_out(113, 8'hF7, 8'hA5, 1'b0, 1'b0, 1'b0);
        add_out(114, 8'hF7, 8'h00, 1'b0, 1'b0, 1'b0);
        add_out(160, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
        add_out(192, 8'hF7, 8'hA5, 1'b0, 1'b0, 1'b0);
        run_vectors();
        forbid_until = 0;

        // Brightness duty, including a change in the middle of a row.
        do_reset();
        add_br(0, 2'd3);
        add_wr(0, 3'd0, 8'hFF);
        add_swap(0);
        add_out(1,  8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
        add_out(80, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) add_out(82 + k, 8'hFE, 8'hFF, 1'b0, 1'b0, 1'b0);
        add_br(100, 2'd1);
        for (int k = 0; k < 8; k++)
            add_out(162 + k, 8'hFE, (k < 4) ? 8'hFF : 8'h00, 1'b0, 1'b0, 1'b0);
        add_br(164, 2'd3);
        for (int k = 0; k < 8; k++) add_out(242 + k, 8'hFE, 8'hFF, 1'b0, 1'b0, 1'b0);
        run_vectors();

        // Swap requested on the last frame cycle, then a doubled request.
        do_reset();
        add_br(0, 2'd3);
        add_wr(0, 3'd2, 8'h81);
        add_rd(50, 3'd2, 8'h81);
        add_swap(79);
        add_out(79,  8'h7F, 8'h00, 1'b0, 1'b0, 1'b0);
        add_out(80,  8'hFF, 8'h00, 1'b1, 1'b1, 1'b0);
        add_rd(81, 3'd2, 8'h00);
        add_swap(85);
        add_out(86,  8'hFE, 8'h00, 1'b0, 1'b0, 1'b1);
        add_swap(90);
        add_out(91,  8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
        add_out(102, 8'hFB, 8'h81, 1'b0, 1'b0, 1'b1);
        add_out(109, 8'hFB, 8'h81, 1'b0, 1'b0, 1'b1);
        add_out(159, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b1);
        add_out(160, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0);
        add_out(161, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        add_out(182, 8'hFB, 8'h00, 1'b0, 1'b0, 1'b0);
        add_rd(200, 3'd2, 8'h81);
        add_out(240, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
        run_vectors();

        // Write landing on the swap edge goes to the bank that becomes visible.
        do_reset();
        add_wr(0, 3'd0, 8'h11);
        add_swap(0);
        add_out(80,  8'hFF, 8'h00, 1'b1, 1'b1, 1'b0);
        add_out(82,  8'hFE, 8'h11, 1'b0, 1'b0, 1'b0);
        add_out(83,  8'hFE, 8'h11, 1'b0, 1'b0, 1'b0);
        add_out(84,  8'hFE, 8'h00, 1'b0, 1'b0, 1'b0);
        add_swap(85);
        add_wr(159, 3'd0, 8'h3C);
        add_rd(159, 3'd0, 8'h00);
        add_out(159, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b1);
        add_out(160, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0);
        add_rd(161, 3'd0, 8'h11);
        add_out(162, 8'hFE, 8'h3C, 1'b0, 1'b0, 1'b0);
        add_out(163, 8'hFE, 8'h3C, 1'b0, 1'b0, 1'b0);
        add_out(164, 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0);
        run_vectors();

        // Reset asserted during row 5 drive with a swap pending.
        do_reset();
        add_br(0, 2'd3);
        add_wr(0, 3'd5, 8'hFF);
        add_swap(0);
        add_out(80,  8'hFF, 8'h00, 1'b1, 1'b1, 1'b0);
        add_swap(100);
        add_out(132, 8'hDF, 8'hFF, 1'b0, 1'b0, 1'b1);
        add_out(134, 8'hDF, 8'hFF, 1'b0, 1'b0, 1'b1);
        run_vectors();
        cyc = 135;
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs();
        for (int a = 0; a < 8; a++) exp_q.push_back(8'h00);
        for (int a = 0; a < 8; a++) begin
            bus.rd_addr = 3'(a);
            #1;
            chk8("rst_rd_data", bus.rd_data, exp_q.pop_front());
        end
        release_reset();
        add_out(0,  8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
        add_out(52, 8'hDF, 8'h00, 1'b0, 1'b0, 1'b0);
        add_swap(53);
        add_out(54, 8'hDF, 8'h00, 1'b0, 1'b0, 1'b1);
        add_out(80, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0);
        add_rd(81, 3'd5, 8'h00);
        run_vectors();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
